// File: rtl/trap_sequencer.sv
// SPARC v8 trap-entry / RETT sequencer: issues PSR field writes one per cycle
// in a fixed order, captures the trap type for TBR and latches error mode.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting; samples trap_req / rett_req / irl by priority
// T_PS  | trap entry: PS <= snapshot S
// T_S   | trap entry: S <= 1
// T_ET  | trap entry: ET <= 0
// T_CWP | trap entry: CWP <= CWP-1 (mod NWINDOWS)
// T_TT  | trap entry: TBR.tt <= captured tt
// R_CWP | RETT: CWP <= CWP+1 (mod NWINDOWS)
// R_S   | RETT: S <= snapshot PS
// R_ET  | RETT: ET <= 1
// DONE  | one-cycle completion pulse, back to IDLE
// ERROR | synchronous trap with ET=0; halted until rst
module trap_sequencer #(
  parameter int NWINDOWS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trap_req,
  input  logic [7:0] trap_tt,
  input  logic [3:0] irl,
  input  logic       rett_req,
  input  logic       psr_S,
  input  logic       psr_PS,
  input  logic       psr_ET,
  input  logic [3:0] psr_PIL,
  input  logic [4:0] psr_CWP,
  output logic       S_set,
  output logic       S_in,
  output logic       PS_set,
  output logic       PS_in,
  output logic       ET_set,
  output logic       ET_in,
  output logic       CWP_wr,
  output logic [4:0] CWP_in,
  output logic       tt_wr,
  output logic [7:0] tt_out,
  output logic       busy,
  output logic       trap_ack,
  output logic       done,
  output logic       error_mode
);

  typedef enum logic [3:0] {
    IDLE, T_PS, T_S, T_ET, T_CWP, T_TT, R_CWP, R_S, R_ET, DONE, ERROR
  } state_t;

  localparam logic [4:0] CWP_MAX = 5'(NWINDOWS - 1);

  state_t     state, state_nx;
  logic       snap_s, snap_ps;
  logic [4:0] snap_cwp;
  logic [7:0] tt_q, tt_nx;
  logic       accept;
  logic       irq_ok;
  logic [4:0] cwp_dec, cwp_inc;

  assign irq_ok  = psr_ET && (irl != 4'd0) && ((irl > psr_PIL) || (irl == 4'hF));
  assign cwp_dec = (snap_cwp == 5'd0) ? CWP_MAX : snap_cwp - 5'd1;
  assign cwp_inc = (snap_cwp == CWP_MAX) ? 5'd0 : snap_cwp + 5'd1;
  assign accept  = (state == IDLE) && (state_nx != IDLE);

  always_comb begin
    state_nx = state;
    tt_nx    = tt_q;
    case (state)
      IDLE: begin
        if (trap_req) begin
          if (!psr_ET) begin
            state_nx = ERROR;
          end else begin
            state_nx = T_PS;
            tt_nx    = trap_tt;
          end
        end else if (rett_req) begin
          if (psr_ET) begin
            state_nx = T_PS;
            tt_nx    = 8'h02;
          end else if (!psr_S) begin
            state_nx = T_PS;
            tt_nx    = 8'h03;
          end else begin
            state_nx = R_CWP;
          end
        end else if (irq_ok) begin
          state_nx = T_PS;
          tt_nx    = {4'h1, irl};
        end
      end
      T_PS:    state_nx = T_S;
      T_S:     state_nx = T_ET;
      T_ET:    state_nx = T_CWP;
      T_CWP:   state_nx = T_TT;
      T_TT:    state_nx = DONE;
      R_CWP:   state_nx = R_S;
      R_S:     state_nx = R_ET;
      R_ET:    state_nx = DONE;
      DONE:    state_nx = IDLE;
      ERROR:   state_nx = ERROR;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      snap_s   <= 1'b0;
      snap_ps  <= 1'b0;
      snap_cwp <= 5'd0;
      tt_q     <= 8'h00;
      trap_ack <= 1'b0;
    end else begin
      state    <= state_nx;
      trap_ack <= accept;
      if (accept) begin
        snap_s   <= psr_S;
        snap_ps  <= psr_PS;
        snap_cwp <= psr_CWP;
        tt_q     <= tt_nx;
      end
    end
  end

  // Moore outputs: everything below is a pure decode of state and snapshots.
  always_comb begin
    S_set      = 1'b0;
    S_in       = 1'b0;
    PS_set     = 1'b0;
    PS_in      = 1'b0;
    ET_set     = 1'b0;
    ET_in      = 1'b0;
    CWP_wr     = 1'b0;
    CWP_in     = 5'd0;
    tt_wr      = 1'b0;
    tt_out     = tt_q;
    busy       = (state != IDLE);
    done       = 1'b0;
    error_mode = 1'b0;
    case (state)
      T_PS: begin
        PS_set = 1'b1;
        PS_in  = snap_s;
      end
      T_S: begin
        S_set = 1'b1;
        S_in  = 1'b1;
      end
      T_ET: begin
        ET_set = 1'b1;
        ET_in  = 1'b0;
      end
      T_CWP: begin
        CWP_wr = 1'b1;
        CWP_in = cwp_dec;
      end
      T_TT:  tt_wr = 1'b1;
      R_CWP: begin
        CWP_wr = 1'b1;
        CWP_in = cwp_inc;
      end
      R_S: begin
        S_set = 1'b1;
        S_in  = snap_ps;
      end
      R_ET: begin
        ET_set = 1'b1;
        ET_in  = 1'b1;
      end
      DONE:    done = 1'b1;
      ERROR:   error_mode = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: a reference model expands each accepted
// request into its per-cycle PSR/TBR write list; a monitor checks every cycle.
module tb_trap_sequencer;
  localparam int NW = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       trap_req = 1'b0;
  logic [7:0] trap_tt = 8'h00;
  logic [3:0] irl = 4'd0;
  logic       rett_req = 1'b0;
  logic       psr_S = 1'b0, psr_PS = 1'b0, psr_ET = 1'b0;
  logic [3:0] psr_PIL = 4'd0;
  logic [4:0] psr_CWP = 5'd0;
  logic       S_set, S_in, PS_set, PS_in, ET_set, ET_in, CWP_wr, tt_wr;
  logic [4:0] CWP_in;
  logic [7:0] tt_out;
  logic       busy, trap_ack, done, error_mode;

  trap_sequencer #(.NWINDOWS(NW)) dut (
    .clk(clk), .rst(rst), .trap_req(trap_req), .trap_tt(trap_tt), .irl(irl),
    .rett_req(rett_req), .psr_S(psr_S), .psr_PS(psr_PS), .psr_ET(psr_ET),
    .psr_PIL(psr_PIL), .psr_CWP(psr_CWP),
    .S_set(S_set), .S_in(S_in), .PS_set(PS_set), .PS_in(PS_in),
    .ET_set(ET_set), .ET_in(ET_in), .CWP_wr(CWP_wr), .CWP_in(CWP_in),
    .tt_wr(tt_wr), .tt_out(tt_out), .busy(busy), .trap_ack(trap_ack),
    .done(done), .error_mode(error_mode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       busy, ack, done, err;
    logic       s_set, s_in, ps_set, ps_in, et_set, et_in, cwp_wr;
    logic [4:0] cwp_in;
    logic       tt_wr;
    logic [7:0] tt;
  } obs_t;

  typedef struct {
    obs_t v;
    bit   tt_dc;
  } exp_t;

  exp_t       q[$];
  int         checks = 0;
  int         errors = 0;
  bit         tt_known = 1'b1;
  logic [7:0] last_tt = 8'h00;

  function automatic obs_t step(input logic [7:0] tt);
    obs_t o = '0;
    o.busy = 1'b1;
    o.tt   = tt;
    return o;
  endfunction

  task automatic push(input obs_t v, input bit dc);
    exp_t e;
    e.v     = v;
    e.tt_dc = dc;
    q.push_back(e);
  endtask

  // Monitor
  obs_t act, expv;
  exp_t cur;
  bit   present;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      act = '{busy, trap_ack, done, error_mode, S_set, S_in, PS_set, PS_in,
              ET_set, ET_in, CWP_wr, CWP_in, tt_wr, tt_out};
      present = busy | trap_ack | done | error_mode | S_set | PS_set | ET_set | CWP_wr | tt_wr;
      checks++;
      if (present) begin
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_activity got %h required idle", act);
        end else begin
          cur  = q.pop_front();
          expv = cur.v;
          if (cur.tt_dc) begin
            act.tt  = 8'h00;
            expv.tt = 8'h00;
          end
          if (act !== expv) begin
            errors++;
            $display("FAIL seq_cycle got %h required %h", act, expv);
          end
        end
      end else begin
        expv    = '0;
        expv.tt = tt_known ? last_tt : act.tt;
        if (q.size() != 0) begin
          cur = q.pop_front();
          errors++;
          $display("FAIL missing_activity got %h required %h", act, cur.v);
        end else if (act !== expv) begin
          errors++;
          $display("FAIL idle_outputs got %h required %h", act, expv);
        end
      end
    end
  end

  task automatic scramble();
    trap_req = 1'($urandom);
    rett_req = 1'($urandom);
    trap_tt  = 8'($urandom);
    irl      = 4'($urandom);
    psr_S    = 1'($urandom);
    psr_PS   = 1'($urandom);
    psr_ET   = 1'($urandom);
    psr_PIL  = 4'($urandom);
    psr_CWP  = 5'($urandom_range(0, NW - 1));
  endtask

  // Drive one IDLE-cycle request (called at a negedge with the DUT idle),
  // predict the outcome, then keep scrambling inputs until idle again.
  task automatic issue(input logic tr, input logic [7:0] ttv, input logic [3:0] irlv,
                       input logic rt, input logic s, input logic ps, input logic et,
                       input logic [3:0] pil, input logic [4:0] cwp, input int rst_at);
    int         kind;
    int         len;
    int         stop;
    logic [7:0] tt;
    obs_t       v;
    trap_req = tr; trap_tt = ttv; irl = irlv; rett_req = rt;
    psr_S = s; psr_PS = ps; psr_ET = et; psr_PIL = pil; psr_CWP = cwp;
    kind = 0;
    tt   = 8'h00;
    if (tr) begin
      if (et) begin kind = 1; tt = ttv; end
      else kind = 3;
    end else if (rt) begin
      if (et) begin kind = 1; tt = 8'h02; end
      else if (!s) begin kind = 1; tt = 8'h03; end
      else kind = 2;
    end else if (et && irlv != 0 && (irlv > pil || irlv == 4'd15)) begin
      kind = 1;
      tt   = 8'h10 + 8'(irlv);
    end
    len  = 0;
    stop = rst_at;
    case (kind)
      1: begin
        v = step(tt); v.ack = 1; v.ps_set = 1; v.ps_in = s;        push(v, 0);
        v = step(tt); v.s_set = 1; v.s_in = 1;                     push(v, 0);
        v = step(tt); v.et_set = 1; v.et_in = 0;                   push(v, 0);
        v = step(tt); v.cwp_wr = 1; v.cwp_in = 5'((int'(cwp) + NW - 1) % NW); push(v, 0);
        v = step(tt); v.tt_wr = 1;                                 push(v, 0);
        v = step(tt); v.done = 1;                                  push(v, 0);
        last_tt  = tt;
        tt_known = 1;
        len      = 6;
      end
      2: begin
        v = step(0); v.ack = 1; v.cwp_wr = 1; v.cwp_in = 5'((int'(cwp) + 1) % NW); push(v, 1);
        v = step(0); v.s_set = 1; v.s_in = ps;                     push(v, 1);
        v = step(0); v.et_set = 1; v.et_in = 1;                    push(v, 1);
        v = step(0); v.done = 1;                                   push(v, 1);
        tt_known = 0;
        len      = 4;
      end
      3: begin
        v = step(0); v.ack = 1; v.err = 1; push(v, 1);
        for (int i = 2; i <= 20; i++) begin
          v = step(0); v.err = 1; push(v, 1);
        end
        tt_known = 0;
        len      = 20;
        stop     = 20;
      end
      default: ;
    endcase
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      scramble();
      if (c == stop) begin
        rst = 1'b1;
        q.delete();
        tt_known = 1;
        last_tt  = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        trap_req = 0; rett_req = 0; irl = 0;
        return;
      end
    end
    @(negedge clk);
    trap_req = 0; rett_req = 0; irl = 0;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    // trap entry at CWP 0 wraps to NWINDOWS-1
    issue(1, 8'h05, 0, 0, 1, 0, 1, 0, 5'd0, 0);
    // RETT wrap from NWINDOWS-1 to 0
    issue(0, 8'h00, 0, 1, 1, 0, 0, 0, 5'd7, 0);
    // interrupt priority
    issue(0, 8'h00, 4'd5, 0, 0, 0, 1, 4'd5, 5'd3, 0);
    issue(0, 8'h00, 4'd6, 0, 0, 0, 1, 4'd5, 5'd3, 0);
    issue(0, 8'h00, 4'd15, 0, 1, 1, 1, 4'd15, 5'd4, 0);
    issue(1, 8'h07, 4'd9, 0, 0, 1, 1, 4'd5, 5'd2, 0);
    // illegal and privileged RETT
    issue(0, 8'h00, 0, 1, 1, 0, 1, 0, 5'd1, 0);
    issue(0, 8'h00, 0, 1, 0, 1, 0, 0, 5'd6, 0);
    // error mode, held 20 cycles then reset
    issue(1, 8'h2A, 4'd3, 1, 1, 1, 0, 0, 5'd5, 0);
    // reset during T_ET, then a fresh trap
    issue(1, 8'h11, 0, 0, 1, 1, 1, 0, 5'd2, 3);
    issue(1, 8'h12, 0, 0, 0, 1, 1, 0, 5'd2, 0);
    for (int n = 0; n < 150; n++) begin
      issue(1'($urandom_range(0, 3) == 0), 8'($urandom), 4'($urandom),
            1'($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
            1'($urandom_range(0, 4) != 0), 4'($urandom),
            5'($urandom_range(0, NW - 1)), 0);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain got %0d entries required 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
